client_traffic_gen: RTL

Parametrised successor to the bus-arbiter client. It generates bus transactions over the rq/ack arbiter interface and adds:
- selectable traffic modes, including burst write-then-readback with data checking
- LFSR-driven random idle gaps
- a configurable address window with correct wrap to the window base
- ack timeout with retry
- a transaction counter
It sits between the arbiter and the test/status logic, one instance per bus master.

---
 rtl/client_traffic_gen_if.sv | 15 +
 rtl/client_traffic_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/client_traffic_gen_if.sv
// Bus between one traffic-generating master and the arbiter.
interface client_traffic_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  rq;
    logic                  ack;
    logic                  wr_ni;
    logic [DATA_WIDTH-1:0] dataW;
    logic [DATA_WIDTH-1:0] dataR;

    modport master (output address, rq, wr_ni, dataW, input ack, dataR);
    modport slave  (input address, rq, wr_ni, dataW, output ack, dataR);
endinterface

// File: rtl/client_traffic_gen.sv
// Bus-master traffic generator: modal write/read/readback bursts over the
// rq/ack arbiter bus, LFSR idle gaps, address window wrap, ack timeout with
// retry and a saturating transaction counter.
module client_traffic_gen #(
    parameter int          DATA_WIDTH  = 8,
    parameter int          ADDR_WIDTH  = 4,
    parameter int          ADDR_BASE   = 0,
    parameter int          ADDR_LIMIT  = 3,
    parameter int          BURST_LEN   = 4,
    parameter int          GAP_BITS    = 2,
    parameter int          TIMEOUT     = 15,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [1:0]             mode,
    client_traffic_gen_if.master   bus,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   mismatch,
    output logic                   timeout,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] txn_count
);
    localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_BITS > 0) ? GAP_BITS : 1;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [15:0]           SEED    = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam logic [TW-1:0]         TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0]         IDX_LAST = IW'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] A_BASE  = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH-1:0] A_LIMIT = ADDR_WIDTH'(ADDR_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t                state, state_nx;
    logic [15:0]           lfsr;
    logic [1:0]            cur_mode;
    logic [IW-1:0]         burst_idx;
    logic                  phase_r;     // mode 10: 0 = write phase, 1 = readback phase
    logic                  boundary;    // burst finished; next REQ starts a new burst
    logic                  retry;       // next REQ repeats the timed-out transaction
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [DATA_WIDTH-1:0] dcnt;
    logic [DATA_WIDTH-1:0] exp_base;
    logic [TW-1:0]         timer;
    logic [GW-1:0]         gap_cnt;

    logic                  start_new, req_ack, req_to, gap_done;
    logic                  enter_req, new_burst, eff_phase;
    logic [1:0]            eff_mode;
    logic [15:0]           lfsr_nx;
    logic [GW-1:0]         gap_sel;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  idx_last;

    function automatic logic wr_sel(input logic [1:0] m, input logic ph, input logic r);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return 1'b1;
            2'b10:   return ph;
            default: return r;
        endcase
    endfunction

    assign bus.rq    = (state == REQ);
    assign bus.dataW = dcnt;
    assign busy      = (state != IDLE);

    assign lfsr_nx  = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign gap_sel  = (GAP_BITS > 0) ? lfsr[GW-1:0] : '0;
    assign addr_inc = (bus.address == A_LIMIT) ? A_BASE : bus.address + ADDR_WIDTH'(1);
    assign idx_last = (burst_idx == IDX_LAST);

    // Next state and the single-cycle events that steer the datapath.
    always_comb begin
        state_nx  = state;
        start_new = 1'b0;
        req_ack   = 1'b0;
        req_to    = 1'b0;
        gap_done  = 1'b0;
        case (state)
            IDLE: if (enable) begin
                state_nx  = REQ;
                start_new = 1'b1;
            end
            REQ: if (bus.ack) begin
                req_ack  = 1'b1;
                state_nx = GAP;
            end else if (TIMEOUT != 0 && timer == TO_LAST) begin
                req_to   = 1'b1;
                state_nx = GAP;
            end
            GAP: if (gap_cnt == '0) begin
                gap_done = 1'b1;
                state_nx = enable ? REQ : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A retry never re-samples mode; a new burst uses the live mode input.
    always_comb begin
        enter_req = start_new | (gap_done & enable);
        new_burst = start_new | (gap_done & enable & boundary & ~retry);
        eff_mode  = new_burst ? mode : cur_mode;
        eff_phase = new_burst ? 1'b0 : phase_r;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Datapath: LFSR, transaction attributes, burst tracking, capture and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr        <= SEED;
            bus.address <= A_BASE;
            bus.wr_ni   <= 1'b1;
            cur_mode    <= 2'b00;
            burst_idx   <= '0;
            phase_r     <= 1'b0;
            boundary    <= 1'b0;
            retry       <= 1'b0;
            start_addr  <= A_BASE;
            dcnt        <= '0;
            exp_base    <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            txn_count   <= '0;
        end else begin
            lfsr     <= lfsr_nx;
            rd_valid <= 1'b0;

            if (enter_req) begin
                timer <= '0;
                retry <= 1'b0;
                if (!retry || start_new)
                    bus.wr_ni <= wr_sel(eff_mode, eff_phase, lfsr[15]);
                if (new_burst) begin
                    cur_mode   <= mode;
                    burst_idx  <= '0;
                    phase_r    <= 1'b0;
                    boundary   <= 1'b0;
                    start_addr <= bus.address;
                    exp_base   <= dcnt;
                end
            end

            if (state == REQ && !bus.ack && TIMEOUT != 0)
                timer <= timer + TW'(1);

            if (req_to) begin
                timeout <= 1'b1;
                retry   <= 1'b1;
                gap_cnt <= '0;
            end

            if (req_ack) begin
                if (txn_count != '1)
                    txn_count <= txn_count + COUNT_WIDTH'(1);
                gap_cnt <= gap_sel;
                if (!bus.wr_ni) begin
                    dcnt <= dcnt + DATA_WIDTH'(1);
                end else begin
                    rd_data  <= bus.dataR;
                    rd_valid <= 1'b1;
                    if (cur_mode == 2'b10 && phase_r &&
                        bus.dataR != exp_base + DATA_WIDTH'(burst_idx))
                        mismatch <= 1'b1;
                end
                if (cur_mode == 2'b10 && !phase_r) begin
                    // End of write phase rewinds to the burst start for readback.
                    if (idx_last) begin
                        phase_r     <= 1'b1;
                        burst_idx   <= '0;
                        bus.address <= start_addr;
                    end else begin
                        burst_idx   <= burst_idx + IW'(1);
                        bus.address <= addr_inc;
                    end
                end else begin
                    bus.address <= addr_inc;
                    if (idx_last) begin
                        burst_idx <= '0;
                        boundary  <= 1'b1;
                    end else begin
                        burst_idx <= burst_idx + IW'(1);
                    end
                end
            end

            if (state == GAP && !gap_done)
                gap_cnt <= gap_cnt - GW'(1);
        end
    end
endmodule
